// File: rtl/lvds_deframer.sv
// Per-lane word aligner for the 5-lane LVDS link: hunts for the flag word, locks after
// two back-to-back flags, then emits aligned 10-bit code words with lock and skew status.
module lvds_deframer #(
  parameter int          PIN_NUM   = 5,
  parameter logic [9:0]  FLAG_WORD = 10'h07E,
  parameter int          GAP_MAX   = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [PIN_NUM-1:0]      serial,
  output logic [10*PIN_NUM-1:0]   word,
  output logic [PIN_NUM-1:0]      word_valid,
  output logic [PIN_NUM-1:0]      flag7E,
  output logic [PIN_NUM-1:0]      lock,
  output logic                    all_locked,
  output logic                    data_valid,
  output logic                    skew_err
);

  typedef enum logic [1:0] {HUNT, CHECK, LOCKED} state_t;

  localparam logic [6:0] GAP_LAST = 7'(GAP_MAX - 1);

  logic [PIN_NUM-1:0] lock_next;
  logic [PIN_NUM-1:0] word_valid_next;

  generate
    for (genvar gi = 0; gi < PIN_NUM; gi++) begin : g_lane
      state_t     state;
      // Only the nine newest bits need to persist; the tenth comes straight off the pin.
      logic [8:0] sh;
      logic [3:0] cnt;
      logic [6:0] gap;
      logic [9:0] word_reg;
      logic       word_valid_reg;
      logic       flag_reg;
      logic       lock_reg;

      logic [9:0] sh_next;
      logic       is_flag;
      logic       boundary;
      logic       gap_out;

      assign sh_next  = {sh, serial[gi]};
      assign is_flag  = (sh_next == FLAG_WORD);
      assign boundary = (cnt == 4'd9);
      assign gap_out  = boundary && !is_flag && (gap == GAP_LAST);

      assign word_valid_next[gi] = (state == LOCKED) && boundary;
      assign lock_next[gi]       = ((state == LOCKED) && !gap_out) ||
                                   ((state == CHECK) && boundary && is_flag);

      always_ff @(posedge clk) begin
        if (rst) begin
          state          <= HUNT;
          sh             <= '0;
          cnt            <= '0;
          gap            <= '0;
          word_reg       <= '0;
          word_valid_reg <= 1'b0;
          flag_reg       <= 1'b0;
          lock_reg       <= 1'b0;
        end else begin
          sh             <= sh_next[8:0];
          word_valid_reg <= word_valid_next[gi];
          lock_reg       <= lock_next[gi];
          cnt            <= boundary ? 4'd0 : cnt + 4'd1;
          case (state)
            HUNT: begin
              cnt <= 4'd0;
              if (is_flag) state <= CHECK;
            end
            CHECK: begin
              if (boundary) begin
                if (is_flag) begin
                  state <= LOCKED;
                  gap   <= '0;
                end else begin
                  state <= HUNT;
                end
              end
            end
            LOCKED: begin
              if (boundary) begin
                word_reg <= sh_next;
                flag_reg <= is_flag;
                if (is_flag) begin
                  gap <= '0;
                end else begin
                  gap <= gap + 7'd1;
                  if (gap == GAP_LAST) state <= HUNT;
                end
              end
            end
            default: state <= HUNT;
          endcase
        end
      end

      assign word[10*gi +: 10] = word_reg;
      assign word_valid[gi]    = word_valid_reg;
      assign flag7E[gi]        = flag_reg;
      assign lock[gi]          = lock_reg;
    end
  endgenerate

  // Skew: every lane is locked but only some of them hit a word boundary this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      all_locked <= 1'b0;
      data_valid <= 1'b0;
      skew_err   <= 1'b0;
    end else begin
      all_locked <= &lock_next;
      data_valid <= (&lock_next) & (&word_valid_next);
      skew_err   <= skew_err | ((&lock_next) & (|word_valid_next) & ~(&word_valid_next));
    end
  end

endmodule

// File: doc/lvds_deframer.md
Name: lvds_deframer

Overview:
- Receive-side counterpart of the 5-lane LVDS serializer.
- Per lane, it takes the MSB-first serial bitstream and finds 10-bit word boundaries using the 10'h07E flag word. It then emits aligned 10-bit code words, with a flag indicator, to the downstream 10b-to-8b decode stage.
- It also reports per-lane and aggregate lock, plus lane-to-lane word skew.

Parameters:
- PIN_NUM, 5, number of serial lanes.
- FLAG_WORD, 10'h07E, alignment/idle code word.
- GAP_MAX, 64, consecutive non-flag words tolerated while locked before lock is dropped (range 2..127).

Ports:
- clk  input  1  receive bit clock; one serial bit per lane per cycle.
- rst  input  1  synchronous, active-high reset.
- serial  input  PIN_NUM  lane i bitstream on serial[i]; MSB of each word first.
- word  output  10*PIN_NUM  lane i code word on word[10i+9:10i].
- word_valid  output  PIN_NUM  per-lane one-cycle strobe; word and flag7E are valid for that lane.
- flag7E  output  PIN_NUM  per-lane: the emitted word equals FLAG_WORD.
- lock  output  PIN_NUM  per-lane: boundary locked.
- all_locked  output  1  AND of lock.
- data_valid  output  1  all lanes strobe word_valid in the same cycle while all_locked.
- skew_err  output  1  sticky lane-skew error.

Behaviour:
- Reset (rst=1 at a clk edge):
  - word=0, word_valid=0, flag7E=0, lock=0, all_locked=0, data_valid=0, skew_err=0.
  - All shift registers cleared; state=HUNT; bit counters and gap counters=0.
  - Reset mid-operation discards any partial word. Lanes re-hunt from the next cycle.
- Per-lane datapath:
  - 10-bit shift register: sh_next = {sh[8:0], serial[i]}; sh <= sh_next every cycle in every state.
  - Bit counter cnt, 0..9, is used in CHECK and LOCKED. It wraps 9 -> 0.
  - A boundary occurs on a cycle with cnt==9; sh_next is then a complete word.
- Per-lane FSM:
  - HUNT: if sh_next==FLAG_WORD, go to CHECK with cnt<=0. Bit-by-bit search; nothing is emitted.
  - CHECK: at a boundary, if sh_next==FLAG_WORD, go to LOCKED with gap<=0. Otherwise return to HUNT. Nothing is emitted from CHECK. Two back-to-back flags are therefore required to lock.
  - LOCKED, at each boundary:
    - word<=sh_next and word_valid<=1 for one cycle.
    - flag7E<=(sh_next==FLAG_WORD).
    - If the word is the flag, gap<=0; otherwise gap<=gap+1.
    - If the non-flag word makes gap reach GAP_MAX: the word is still emitted, state->HUNT, and lock falls on the same edge that word_valid rises.
  - lock is a register equal to (state==LOCKED), updated on the same edge as the state.
- Latency: the last bit of a word sampled at edge t -> word_valid high for the cycle after edge t (one register stage).
- word holds its last value between strobes; flag7E likewise.
- Aggregate outputs, all registered:
  - all_locked = &lock_next.
  - data_valid = all_locked_next & (&word_valid_next).
  - skew_err is set when all_locked_next=1 and word_valid_next is neither all-0 nor all-1. It is cleared only by rst.
- Simultaneous events:
  - A flag appearing mid-word while LOCKED is ignored; no realignment without loss of lock.
  - A HUNT-state flag detection in the same cycle as rst: rst wins.
- Gap counter is 7 bits; it saturates by construction because the lane leaves LOCKED at GAP_MAX.

Test Plan:
- Lock acquisition: lane 0 gets zeros, then FLAG, FLAG, data 10'h2A5, MSB first -> lock[0] rises 1 cycle after the last bit of the second flag. word_valid[0] pulses once with word[9:0]=10'h2A5 and flag7E[0]=0, 1 cycle after its last bit.
- False start: a single FLAG followed by 10'h155 -> lane returns to HUNT and lock stays 0. A subsequent FLAG, FLAG locks normally.
- Flag passthrough and data_valid:
  - All 5 lanes aligned: FLAG, FLAG, then FLAG with words 10'h001..10'h005.
  - Required: data_valid pulses for both words; flag7E=5'b11111, then 5'b00000.
  - Required: word=={10'h005,10'h004,10'h003,10'h002,10'h001}; skew_err stays 0.
- Loss of lock: with GAP_MAX=4, lane 2 locked, then 4 consecutive non-flag words -> all 4 emitted. lock[2] and all_locked fall on the edge of the 4th word_valid; the lane then re-hunts.
- Skew: lanes locked with lane 3 delayed 1 bit -> word_valid differs across lanes while all_locked=1, so skew_err=1 and stays set. data_valid never pulses.
- Reset mid-word: rst asserted for 1 cycle 5 bits into a locked word -> all outputs 0 on the next cycle. No word_valid for the partial word; lock requires FLAG, FLAG again.
